// File: rtl/color_pkg.sv
// Shared types for the RGB565 pixel serializer: input formats, the expanded
// pixel word and the byte-serializer states.
package color_pkg;

   typedef enum logic [1:0] {
      MODE_RGB332 = 2'd0,
      MODE_GRAY8  = 2'd1,
      MODE_RGB565 = 2'd2,
      MODE_RSVD   = 2'd3
   } pix_mode_t;

   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_B0   = 2'd1,
      S_B1   = 2'd2
   } ser_state_t;

endpackage

// File: rtl/color_expand.sv
// Combinational colour expansion of RGB332 / GRAY8 / RGB565 input to RGB565.
// Narrow channels are widened by replicating their MSBs so full scale stays full scale.
module color_expand
   import color_pkg::*;
(
   input  pix_mode_t   i_mode,
   input  logic [15:0] i_pix,
   output rgb565_t     o_rgb
);

   logic [7:0] w_p8;
   assign w_p8 = i_pix[7:0];

   always_comb begin
      o_rgb = rgb565_t'(i_pix);
      case (i_mode)
         MODE_RGB332: begin
            o_rgb.r = {w_p8[7:5], w_p8[7:6]};
            o_rgb.g = {w_p8[4:2], w_p8[4:2]};
            o_rgb.b = {w_p8[1:0], w_p8[1:0], w_p8[1]};
         end
         MODE_GRAY8: begin
            o_rgb.r = w_p8[7:3];
            o_rgb.g = w_p8[7:2];
            o_rgb.b = w_p8[7:3];
         end
         default: o_rgb = rgb565_t'(i_pix);
      endcase
   end

endmodule

// File: rtl/pixel_stream_rgb565.sv
// Pixel-to-byte serializer for the TFT SPI path: converts one pixel per handshake
// to RGB565, emits it as two bytes and counts pixels per frame.
module pixel_stream_rgb565
   import color_pkg::*;
#(
   parameter int FRAME_PIXELS = 20480,
   parameter bit SWAP_BYTES   = 1'b0,
   parameter int CNT_W        = $clog2(FRAME_PIXELS)
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_mode,
   input  logic [15:0]      i_pix_in,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic [7:0]       o_out_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_frame_done,
   output logic [CNT_W-1:0] o_pix_count
);

   // state  | meaning
   // S_IDLE | no pixel held, ready for input
   // S_B0   | presenting first byte of held pixel
   // S_B1   | presenting second byte; may accept next pixel on consume

   ser_state_t       r_state;
   ser_state_t       w_state_nxt;
   rgb565_t          r_word;
   rgb565_t          w_rgb;
   logic [CNT_W-1:0] r_pix_count;
   logic             r_frame_done;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_load;
   logic             w_b1_done;
   logic             w_last_pix;
   logic [15:0]      w_word;
   logic [7:0]       w_first;
   logic [7:0]       w_second;

   color_expand u_color_expand (
      .i_mode (pix_mode_t'(i_mode)),
      .i_pix  (i_pix_in),
      .o_rgb  (w_rgb)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_load      = 1'b0;
      w_b1_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (i_in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_B0;
            end
         end
         S_B0: begin
            w_out_valid = 1'b1;
            if (i_out_ready) w_state_nxt = S_B1;
         end
         S_B1: begin
            w_out_valid = 1'b1;
            w_in_ready  = i_out_ready;
            if (i_out_ready) begin
               w_b1_done = 1'b1;
               if (i_in_valid) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_B0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_last_pix = (r_pix_count == CNT_W'(FRAME_PIXELS - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_word       <= '0;
         r_pix_count  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_frame_done <= w_b1_done && w_last_pix;
         if (w_load) r_word <= w_rgb;
         if (w_b1_done) begin
            if (w_last_pix) r_pix_count <= '0;
            else            r_pix_count <= r_pix_count + 1'b1;
         end
      end
   end

   assign w_word   = r_word;
   assign w_first  = SWAP_BYTES ? w_word[7:0]  : w_word[15:8];
   assign w_second = SWAP_BYTES ? w_word[15:8] : w_word[7:0];

   // Ready is withheld while reset is asserted so nothing is taken mid-reset.
   assign o_in_ready   = w_in_ready && i_rst_n;
   assign o_out_valid  = w_out_valid;
   assign o_out_data   = (r_state == S_B0) ? w_first :
                         (r_state == S_B1) ? w_second : 8'h00;
   assign o_frame_done = r_frame_done;
   assign o_pix_count  = r_pix_count;

endmodule

// File: tb/tb_pixel_stream_rgb565.sv
// Directed bench for pixel_stream_rgb565: default, byte-swapped and 4-pixel-frame
// instances share one stimulus stream; each is checked against hand-computed bytes.
module tb_pixel_stream_rgb565;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic [15:0] pix;
   logic        in_valid;
   logic        out_ready;

   logic        a_in_ready, a_valid, a_fd;
   logic [7:0]  a_data;
   logic [14:0] a_cnt;
   logic        s_in_ready, s_valid, s_fd;
   logic [7:0]  s_data;
   logic [14:0] s_cnt;
   logic        f_in_ready, f_valid, f_fd;
   logic [7:0]  f_data;
   logic [1:0]  f_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pixel_stream_rgb565 dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_pix_in(pix),
      .i_in_valid(in_valid), .o_in_ready(a_in_ready), .o_out_data(a_data),
      .o_out_valid(a_valid), .i_out_ready(out_ready), .o_frame_done(a_fd),
      .o_pix_count(a_cnt)
   );

   pixel_stream_rgb565 #(.SWAP_BYTES(1'b1)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_pix_in(pix),
      .i_in_valid(in_valid), .o_in_ready(s_in_ready), .o_out_data(s_data),
      .o_out_valid(s_valid), .i_out_ready(out_ready), .o_frame_done(s_fd),
      .o_pix_count(s_cnt)
   );

   pixel_stream_rgb565 #(.FRAME_PIXELS(4)) dut_f (
      .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_pix_in(pix),
      .i_in_valid(in_valid), .o_in_ready(f_in_ready), .o_out_data(f_data),
      .o_out_valid(f_valid), .i_out_ready(out_ready), .o_frame_done(f_fd),
      .o_pix_count(f_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pv(input int k);
      return 16'((k + 1) * 16'h0103);
   endfunction

   task automatic single_pix(input string tag, input logic [1:0] m, input logic [15:0] p,
                             input logic [7:0] hi, input logic [7:0] lo);
      mode = m; pix = p; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, a_in_ready, 1);
      tick();
      in_valid = 1'b0;
      mode = ~m; pix = ~p;
      #1;
      chk({tag, "_v0"}, a_valid, 1);
      chk({tag, "_b0"}, a_data, hi);
      chk({tag, "_sw_b0"}, s_data, lo);
      chk({tag, "_rdy_b0"}, a_in_ready, 0);
      tick();
      chk({tag, "_b1"}, a_data, lo);
      chk({tag, "_sw_b1"}, s_data, hi);
      tick();
      chk({tag, "_idle"}, a_valid, 0);
   endtask

   task automatic stream(input string tag, input int n, input bit frm);
      logic [15:0] w;
      int k;
      mode = 2'd2; out_ready = 1'b1; in_valid = 1'b1; pix = pv(0);
      tick();
      for (int c = 0; c < 2 * n; c++) begin
         k = c / 2;
         w = pv(k);
         chk({tag, "_valid"}, a_valid, 1);
         chk({tag, "_data"}, a_data, (c % 2 == 0) ? w[15:8] : w[7:0]);
         chk({tag, "_rdy"}, a_in_ready, c % 2);
         if (frm) begin
            chk({tag, "_fdone"}, f_fd, (c == 8 || c == 16));
            chk({tag, "_cnt"}, f_cnt, k % 4);
         end
         if (c % 2 == 0) begin
            if (k + 1 < n) pix = pv(k + 1);
            else           in_valid = 1'b0;
         end
         tick();
      end
      chk({tag, "_end_idle"}, a_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; mode = 2'd0; pix = 16'h0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", a_valid, 0);
      chk("rst_data", a_data, 8'h00);
      chk("rst_fdone", a_fd, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_rdy_in_reset", a_in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_rdy_after", a_in_ready, 1);

      single_pix("rgb332_92", 2'd0, 16'h0092, 8'h94, 8'h95);
      single_pix("rgb332_ff", 2'd0, 16'hAAFF, 8'hFF, 8'hFF);
      single_pix("rgb332_e0", 2'd0, 16'h00E0, 8'hF8, 8'h00);
      single_pix("rgb332_03", 2'd0, 16'h0003, 8'h00, 8'h1F);
      single_pix("gray_80",   2'd1, 16'h0080, 8'h84, 8'h10);
      single_pix("rgb565",    2'd2, 16'hBEEF, 8'hBE, 8'hEF);
      single_pix("mode3",     2'd3, 16'h1357, 8'h13, 8'h57);

      stream("st10", 10, 1'b0);
      chk("cnt_after_stream", a_cnt, 17);

      // Backpressure in both byte phases while the source holds the next pixel.
      mode = 2'd2; pix = 16'h1234; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      pix = 16'h5678;
      for (int i = 0; i < 5; i++) begin
         chk("stall_b0_valid", a_valid, 1);
         chk("stall_b0_data", a_data, 8'h12);
         chk("stall_b0_rdy", a_in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_b1_valid", a_valid, 1);
         chk("stall_b1_data", a_data, 8'h34);
         chk("stall_b1_rdy", a_in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("stall_b1_rdy_on", a_in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("stall_next_b0", a_data, 8'h56);
      tick();
      chk("stall_next_b1", a_data, 8'h78);
      tick();
      chk("stall_idle", a_valid, 0);
      chk("cnt_after_stall", a_cnt, 19);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("frm_cnt_start", f_cnt, 0);
      stream("frm", 9, 1'b1);
      chk("frm_cnt_end", f_cnt, 1);
      chk("frm_fdone_end", f_fd, 0);

      // Reset while stalled in the second byte drops the pixel.
      mode = 2'd2; pix = 16'hABCD; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      #1;
      chk("rstb1_pre_data", a_data, 8'hCD);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("rstb1_valid", a_valid, 0);
      chk("rstb1_cnt", a_cnt, 0);
      chk("rstb1_data", a_data, 8'h00);
      chk("rstb1_rdy", a_in_ready, 1);
      single_pix("after_rst", 2'd2, 16'h4321, 8'h43, 8'h21);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
